// File: rtl/code_rom_arbiter.sv
`timescale 1ns/1ps
// Arbitrates one single-port code ROM between the tracking (TE) and acquisition (AE)
// engines; read data is returned to the winner through a tag pipeline matched to ROM latency.
module code_rom_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int ROM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  te_rd,
  input  logic [ADDR_WIDTH-1:0] te_addr,
  output logic                  te_gnt,
  output logic                  te_data_valid,
  output logic [DATA_WIDTH-1:0] te_data,
  input  logic                  ae_rd,
  input  logic [ADDR_WIDTH-1:0] ae_addr,
  output logic                  ae_gnt,
  output logic                  ae_data_valid,
  output logic [DATA_WIDTH-1:0] ae_data,
  output logic                  rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  cnt_clear,
  output logic [15:0]           conflict_cnt
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          force_ae;
  logic [1:0]    tag_q [ROM_LATENCY];
  logic [1:0]    tag_out;

  // Handshake: a read is accepted in a cycle where *_rd and *_gnt are both high; a
  // denied requester holds *_rd and *_addr until granted, nothing is queued here.
  always_comb begin
    force_ae = ae_rd && (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
    ae_gnt   = ae_rd && (!te_rd || force_ae);
    te_gnt   = te_rd && !ae_gnt;
    rom_rd   = te_gnt || ae_gnt;
    rom_addr = ae_gnt ? ae_addr : te_addr;
  end

  // Counts consecutive denied AE cycles; reaching the limit forces one AE grant.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      starve_cnt <= '0;
    end else if (ae_gnt || !ae_rd) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // {te_tag, ae_tag} travels alongside the ROM access so data reaches its owner.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {te_gnt, ae_gnt};
      for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[ROM_LATENCY-1];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      te_data_valid <= 1'b0;
      te_data       <= '0;
      ae_data_valid <= 1'b0;
      ae_data       <= '0;
    end else begin
      te_data_valid <= tag_out[1];
      ae_data_valid <= tag_out[0];
      if (tag_out[1]) te_data <= rom_rdata;
      if (tag_out[0]) ae_data <= rom_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      conflict_cnt <= '0;
    end else if (cnt_clear) begin
      conflict_cnt <= '0;
    end else if (te_rd && ae_rd && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule
